// File: rtl/sistema_cpu_mul_iter.sv
// ============================================================================
// sistema_cpu_mul_iter
// ----------------------------------------------------------------------------
// Iterative multiplier for the CPU datapath. It sits between the E-stage
// operand latch and the M/W result mux. It multiplies two WIDTH-bit operands
// by accumulating one SLICE x SLICE partial product per clock into a 2*WIDTH
// accumulator. The operands are first reduced to magnitudes, and the sign is
// applied once at the end. This keeps every partial product unsigned.
//
// Operation sequence: IDLE -> CALC (N cycles) -> NEG (1 cycle) -> DONE.
// Here N = (WIDTH/SLICE)^2. A result appears N+1 edges after the accept
// edge. With out_ready held high, one operation completes every N+3 cycles.
//
// Parameters
//   WIDTH      operand width (must be a multiple of SLICE)
//   SLICE      partial-product slice width
//
// Ports
//   clk        clock; all state updates on the rising edge
//   reset      synchronous, active-high; highest priority
//   in_valid   operands/op valid
//   in_ready   block can accept an operation (high only in IDLE)
//   in_op      00 MUL (low word), 01 MULH (s*s), 10 MULHSU (s*u), 11 MULHU (u*u)
//   in_src1    operand A (signed for MULH / MULHSU)
//   in_src2    operand B (signed for MULH only)
//   flush      pipeline kill: abort any operation, return to IDLE
//   out_valid  result valid; held until out_ready
//   out_ready  consumer accepts the result
//   out_result low word (MUL) or high word (others) of the 2*WIDTH product
// ============================================================================
module sistema_cpu_mul_iter #(
    parameter int WIDTH = 32,
    parameter int SLICE = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_src1,
    input  logic [WIDTH-1:0] in_src2,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int NS    = WIDTH / SLICE;          // slices per operand
    localparam int N     = NS * NS;                // partial products per op
    localparam int IDX_W = $clog2(N) + 1;          // holds 0..N
    localparam int SH_W  = $clog2(2 * WIDTH) + 1;  // holds any shift < 2*WIDTH

    localparam logic [IDX_W-1:0] NS_I    = IDX_W'(NS);
    localparam logic [IDX_W-1:0] LAST_I  = IDX_W'(N - 1);
    localparam logic [IDX_W-1:0] ONE_I   = IDX_W'(1);
    localparam logic [SH_W-1:0]  SLICE_S = SH_W'(SLICE);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_NEG  = 2'b10,
        ST_DONE = 2'b11
    } state_e;

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULH   = 2'b01,
        OP_MULHSU = 2'b10,
        OP_MULHU  = 2'b11
    } op_e;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_e             state_q;
    state_e             state_d;
    op_e                op_q;
    logic [WIDTH-1:0]   mag_a_q;
    logic [WIDTH-1:0]   mag_b_q;
    logic               neg_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [IDX_W-1:0]   idx_q;
    logic [WIDTH-1:0]   result_q;

    // ------------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------------
    logic accept;

    assign in_ready   = (state_q == ST_IDLE);
    assign out_valid  = (state_q == ST_DONE);
    assign out_result = result_q;

    // A flush in the same cycle as in_valid kills the new request too.
    assign accept = in_valid && in_ready && !flush;

    // ------------------------------------------------------------------------
    // Operand decode: magnitudes and result sign
    // ------------------------------------------------------------------------
    op_e              in_op_e;
    logic             a_signed;
    logic             b_signed;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] mag_a_d;
    logic [WIDTH-1:0] mag_b_d;

    assign in_op_e = op_e'(in_op);

    // NOTE: every output of a combinational block gets a default before any
    // branch, so no path can leave a value unassigned and infer a latch.
    always_comb begin
        a_signed = (in_op_e == OP_MULH) || (in_op_e == OP_MULHSU);
        b_signed = (in_op_e == OP_MULH);
        a_neg    = a_signed && in_src1[WIDTH-1];
        b_neg    = b_signed && in_src2[WIDTH-1];
        // -(-2^(WIDTH-1)) wraps to 2^(WIDTH-1), which is the correct
        // magnitude when it is read as unsigned.
        mag_a_d  = a_neg ? -in_src1 : in_src1;
        mag_b_d  = b_neg ? -in_src2 : in_src2;
    end

    // ------------------------------------------------------------------------
    // Partial product for the current idx.
    // The A slice index i runs fastest: i = idx % NS, j = idx / NS.
    // The product is placed at bit SLICE*(i+j).
    // ------------------------------------------------------------------------
    logic [IDX_W-1:0]   i_idx;
    logic [IDX_W-1:0]   j_idx;
    logic [SH_W-1:0]    a_sh;
    logic [SH_W-1:0]    b_sh;
    logic [SH_W-1:0]    pp_sh;
    logic [SLICE-1:0]   a_sl;
    logic [SLICE-1:0]   b_sl;
    logic [2*SLICE-1:0] pp;
    logic [2*WIDTH-1:0] pp_ext;
    logic [2*WIDTH-1:0] pp_wide;
    logic [2*WIDTH-1:0] acc_fix;

    always_comb begin
        i_idx   = idx_q % NS_I;
        j_idx   = idx_q / NS_I;
        a_sh    = SH_W'(i_idx) * SLICE_S;
        b_sh    = SH_W'(j_idx) * SLICE_S;
        pp_sh   = a_sh + b_sh;
        a_sl    = SLICE'(mag_a_q >> a_sh);
        b_sl    = SLICE'(mag_b_q >> b_sh);
        pp      = {{SLICE{1'b0}}, a_sl} * {{SLICE{1'b0}}, b_sl};
        pp_ext  = '0;
        pp_ext[2*SLICE-1:0] = pp;
        pp_wide = pp_ext << pp_sh;
        // Apply the sign once, on the full 2*WIDTH magnitude.
        acc_fix = neg_q ? -acc_q : acc_q;
    end

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples its inputs as they were before the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (accept)          state_d = ST_CALC;
            ST_CALC: if (idx_q == LAST_I) state_d = ST_NEG;
            ST_NEG:                       state_d = ST_DONE;
            ST_DONE: if (out_ready)       state_d = ST_IDLE;
            default:                      state_d = ST_IDLE;
        endcase
        // Flush overrides every transition except reset.
        if (flush) begin
            state_d = ST_IDLE;
        end
    end

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    // NOTE: the datapath is a handful of flops, not a memory array, so all of
    // it is reset. After a reset the block is fully defined with no
    // operation in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q     <= OP_MUL;
            mag_a_q  <= '0;
            mag_b_q  <= '0;
            neg_q    <= 1'b0;
            acc_q    <= '0;
            idx_q    <= '0;
            result_q <= '0;
        end else if (!flush) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        op_q    <= in_op_e;
                        mag_a_q <= mag_a_d;
                        mag_b_q <= mag_b_d;
                        neg_q   <= a_neg ^ b_neg;
                        acc_q   <= '0;
                        idx_q   <= '0;
                    end
                end
                ST_CALC: begin
                    acc_q <= acc_q + pp_wide;
                    idx_q <= idx_q + ONE_I;
                end
                ST_NEG: begin
                    acc_q    <= acc_fix;
                    result_q <= (op_q == OP_MUL) ? acc_fix[WIDTH-1:0]
                                                 : acc_fix[2*WIDTH-1:WIDTH];
                end
                ST_DONE: begin
                    // Hold the result until it is consumed.
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sistema_cpu_mul_iter.sv
// ============================================================================
// tb_sistema_cpu_mul_iter
// ----------------------------------------------------------------------------
// Self-checking bench with two instances: WIDTH=32/SLICE=16 and
// WIDTH=24/SLICE=8. When an operation is accepted, its expected result is
// pushed to a per-instance queue. The result is popped and compared when
// that instance hands it over (out_valid && out_ready).
// ============================================================================
`timescale 1ns/1ps
module tb_sistema_cpu_mul_iter;

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;
    localparam logic [1:0] OP_MULHU  = 2'b11;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- 32/16 instance ----------------
    logic        in_valid, in_ready, flush, out_valid, out_ready;
    logic [1:0]  in_op;
    logic [31:0] in_src1, in_src2, out_result;
    logic [1:0]  rdy_mode;   // 0 always ready, 1 random, 2 stalled
    logic        rnd_a;

    // ---------------- 24/8 instance -----------------
    logic        in_valid_b, in_ready_b, flush_b, out_valid_b, out_ready_b;
    logic [1:0]  in_op_b;
    logic [23:0] in_src1_b, in_src2_b, out_result_b;
    logic [1:0]  rdy_mode_b;
    logic        rnd_b;

    always @(posedge clk) begin
        rnd_a <= 1'($urandom_range(0, 1));
        rnd_b <= 1'($urandom_range(0, 1));
    end

    assign out_ready   = (rdy_mode == 2'd0)   || (rdy_mode == 2'd1   && rnd_a);
    assign out_ready_b = (rdy_mode_b == 2'd0) || (rdy_mode_b == 2'd1 && rnd_b);

    sistema_cpu_mul_iter #(.WIDTH(32), .SLICE(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_src1    (in_src1),
        .in_src2    (in_src2),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result)
    );

    sistema_cpu_mul_iter #(.WIDTH(24), .SLICE(8)) dut_b (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid_b),
        .in_ready   (in_ready_b),
        .in_op      (in_op_b),
        .in_src1    (in_src1_b),
        .in_src2    (in_src2_b),
        .flush      (flush_b),
        .out_valid  (out_valid_b),
        .out_ready  (out_ready_b),
        .out_result (out_result_b)
    );

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: sign- or zero-extend each operand to 64 bits, multiply,
    // then pick the low or high w-bit word of the 2w-bit product.
    function automatic logic [63:0] ref_mul(input int w, input logic [1:0] op,
                                            input logic [63:0] a, input logic [63:0] b);
        logic [63:0] mask, ae, be, p;
        mask = (64'd1 << w) - 64'd1;
        ae   = a & mask;
        be   = b & mask;
        if ((op == OP_MULH || op == OP_MULHSU) && ae[w-1]) ae = ae | ~mask;
        if (op == OP_MULH && be[w-1]) be = be | ~mask;
        p = ae * be;
        return (op == OP_MUL) ? (p & mask) : ((p >> w) & mask);
    endfunction

    // ---------------- scoreboards ----------------
    logic [31:0] exp_q[$];
    logic [23:0] exp_q_b[$];

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) check("unexpected_out", 64'(out_valid), 64'd0);
            else                   check("result", 64'(out_result), 64'(exp_q.pop_front()));
        end
        if (!reset && out_valid_b && out_ready_b) begin
            if (exp_q_b.size() == 0) check("unexpected_out_b", 64'(out_valid_b), 64'd0);
            else                     check("result_b", 64'(out_result_b), 64'(exp_q_b.pop_front()));
        end
    end

    // ---------------- drivers ----------------
    // Called just after a rising edge. Returns 1 ns after the accept edge.
    task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input bit push);
        int n = 0;
        in_valid = 1'b1; in_op = op; in_src1 = a; in_src2 = b;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("accept_wait", 64'(in_ready), 64'd1);
        if (push) exp_q.push_back(exp);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_b(input logic [1:0] op, input logic [23:0] a, input logic [23:0] b,
                          input logic [23:0] exp);
        int n = 0;
        in_valid_b = 1'b1; in_op_b = op; in_src1_b = a; in_src2_b = b;
        @(negedge clk);
        while (!in_ready_b && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("accept_wait_b", 64'(in_ready_b), 64'd1);
        exp_q_b.push_back(exp);
        @(posedge clk); #1;
        in_valid_b = 1'b0;
    endtask

    task automatic drain;
        int n = 0;
        while ((exp_q.size() != 0 || out_valid || !in_ready) && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic drain_b;
        int n = 0;
        while ((exp_q_b.size() != 0 || out_valid_b || !in_ready_b) && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_b", 64'(exp_q_b.size()), 64'd0);
    endtask

    function automatic logic [31:0] pick(input int w);
        logic [31:0] mask, v;
        mask = (32'd1 << w) - 32'd1;
        if (w == 32) mask = 32'hFFFF_FFFF;
        case ($urandom_range(0, 5))
            0:       v = 32'd0;
            1:       v = 32'd1 << (w - 1);
            2:       v = 32'hFFFF_FFFF;
            3:       v = 32'd1;
            default: v = $urandom;
        endcase
        return v & mask;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- main sequence ----------------
    initial begin
        int          c0;
        logic        seen;
        logic [1:0]  op;
        logic [31:0] a, b;

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_op = 2'b00;
        in_src1 = '0; in_src2 = '0; rdy_mode = 2'd0;
        flush_b = 1'b0; in_valid_b = 1'b0; in_op_b = 2'b00;
        in_src1_b = '0; in_src2_b = '0; rdy_mode_b = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_result", 64'(out_result), 64'd0);
        check("rst_in_ready_b", 64'(in_ready_b), 64'd1);
        reset = 1'b0;

        // Directed values
        send(OP_MUL,    32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1);
        send(OP_MULHU,  32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 1);
        send(OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1);
        send(OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1);
        send(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
        send(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1);
        send(OP_MUL,    32'hFFFF_FFFF, 32'h0000_0003, 32'hFFFF_FFFD, 1);
        drain();

        // Latency and handshake: accept at edge 0
        send(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1);
        check("lat0_in_ready", 64'(in_ready), 64'd0);
        check("lat0_out_valid", 64'(out_valid), 64'd0);
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            check("lat_out_valid_low", 64'(out_valid), 64'd0);
            check("lat_in_ready_low", 64'(in_ready), 64'd0);
        end
        @(posedge clk); #1;   // edge 5
        check("lat5_out_valid", 64'(out_valid), 64'd1);
        check("lat5_in_ready", 64'(in_ready), 64'd0);
        check("lat5_result", 64'(out_result), 64'hFFFF_FFFE);
        @(posedge clk); #1;   // edge 6: result consumed
        check("lat6_out_valid", 64'(out_valid), 64'd0);
        check("lat6_in_ready", 64'(in_ready), 64'd1);
        c0 = cyc;
        send(OP_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1);
        check("next_accept_edge", 64'(cyc - c0), 64'd1);

        // Backpressure: the result must hold while out_ready is low
        rdy_mode = 2'd2;
        for (int n = 0; n < 20 && !out_valid; n++) begin
            @(posedge clk); #1;
        end
        check("bp_valid_seen", 64'(out_valid), 64'd1);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check("bp_hold_valid", 64'(out_valid), 64'd1);
            check("bp_hold_result", 64'(out_result), 64'h4000_0000);
        end
        rdy_mode = 2'd0;
        drain();

        // Reset in CALC with idx=2
        send(OP_MUL, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 0);
        @(posedge clk); #1;   // edge 1
        @(posedge clk); #1;   // edge 2, idx=2
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("mid_rst_in_ready", 64'(in_ready), 64'd1);
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_out_result", 64'(out_result), 64'd0);
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            seen = seen | out_valid;
        end
        check("mid_rst_no_output", 64'(seen), 64'd0);

        // Flush in CALC together with in_valid
        send(OP_MUL, 32'h0000_0007, 32'h0000_0009, 32'd0, 0);
        @(posedge clk); #1;   // edge 1, in CALC
        flush = 1'b1; in_valid = 1'b1; in_op = OP_MULHSU;
        in_src1 = 32'hFFFF_FFFF; in_src2 = 32'hFFFF_FFFF;
        @(posedge clk); #1;   // edge 2: flushed, request ignored
        check("flush_idle", 64'(in_ready), 64'd1);
        check("flush_out_valid", 64'(out_valid), 64'd0);
        flush = 1'b0;
        exp_q.push_back(32'hFFFF_FFFF);
        @(posedge clk); #1;   // edge 3: accepted now
        check("flush_next_accept", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        drain();

        // Random vs reference model, 32/16, random backpressure
        rdy_mode = 2'd1;
        for (int t = 0; t < 40; t++) begin
            op = 2'($urandom_range(0, 3));
            a  = pick(32);
            b  = pick(32);
            send(op, a, b, 32'(ref_mul(32, op, 64'(a), 64'(b))), 1);
        end
        drain();
        rdy_mode = 2'd0;

        // Random vs reference model, 24/8, random backpressure
        rdy_mode_b = 2'd1;
        for (int t = 0; t < 40; t++) begin
            op = 2'($urandom_range(0, 3));
            a  = pick(24);
            b  = pick(24);
            send_b(op, 24'(a), 24'(b), 24'(ref_mul(24, op, 64'(a), 64'(b))));
        end
        drain_b();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
